// File: rtl/movie_theater_max_rect.sv
// Streams up to MAX_POINTS (x,y) points into a local memory and, on start, scans every
// unordered pair (i<j) with NUM_ENGINES lanes. It reports the largest inclusive rectangle
// area (|xi-xj|+1)*(|yi-yj|+1) and the lexicographically smallest pair that achieves it.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  point load handshake; in_x/in_y carry the coordinates
//   clear              empties the point memory (IDLE/DONE only)
//   start              scans the points currently loaded (IDLE/DONE only)
//   busy               high while scanning or draining the pipeline
//   finished           high while the result is held in DONE
//   result             best area; best_i/best_j give the winning pair, best_i < best_j
module movie_theater_max_rect #(
    parameter int unsigned MAX_POINTS  = 512,
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned NUM_ENGINES = 8,
    parameter int unsigned IDX_WIDTH   = $clog2(MAX_POINTS + 1),
    parameter int unsigned AREA_WIDTH  = 2 * COORD_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    input  logic                   clear,
    input  logic                   start,
    output logic                   busy,
    output logic                   finished,
    output logic [AREA_WIDTH-1:0]  result,
    output logic [IDX_WIDTH-1:0]   best_i,
    output logic [IDX_WIDTH-1:0]   best_j
);

    localparam int unsigned LOG_NE = $clog2(NUM_ENGINES);
    localparam int unsigned ADDR_W = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
    localparam int unsigned WIDE_W = COORD_WIDTH + 1;
    // Valid bits for S1..S6 plus the max-tree levels; the global update is the last stage.
    localparam int unsigned VLD_W  = 6 + LOG_NE;
    // Heap-ordered max tree: node n has children 2n+1 (lower lanes) and 2n+2.
    localparam int unsigned NODES  = 2 * NUM_ENGINES - 1;

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [IDX_WIDTH-1:0]   count_q, i_q, j_q;
    logic [AREA_WIDTH-1:0]  result_q;
    logic [IDX_WIDTH-1:0]   best_i_q, best_j_q;
    logic                   busy_q, finished_q;
    logic [VLD_W-1:0]       vld_q;

    logic [COORD_WIDTH-1:0] mem_x [MAX_POINTS];
    logic [COORD_WIDTH-1:0] mem_y [MAX_POINTS];

    logic idle_like, accept, do_clear, do_start, few_points, issue, j_step, i_step;

    logic [ADDR_W-1:0]      lane_addr [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] lane_ok;

    // Pipeline data; these registers need no reset because vld_q qualifies them.
    logic [COORD_WIDTH-1:0] xi1, yi1;
    logic [COORD_WIDTH-1:0] xj1 [NUM_ENGINES];
    logic [COORD_WIDTH-1:0] yj1 [NUM_ENGINES];
    logic [COORD_WIDTH-1:0] dx2 [NUM_ENGINES];
    logic [COORD_WIDTH-1:0] dy2 [NUM_ENGINES];
    logic [WIDE_W-1:0]      wx3 [NUM_ENGINES];
    logic [WIDE_W-1:0]      wy3 [NUM_ENGINES];
    logic [AREA_WIDTH-1:0]  p4  [NUM_ENGINES];
    logic [AREA_WIDTH-1:0]  p5  [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] lv1, lv2, lv3;
    logic [IDX_WIDTH-1:0]   i1, i2, i3, i4, i5, j1, j2, j3, j4, j5;
    logic [AREA_WIDTH-1:0]  node_area [NODES];
    logic [IDX_WIDTH-1:0]   node_i    [NODES];
    logic [IDX_WIDTH-1:0]   node_j    [NODES];

    function automatic logic [COORD_WIDTH-1:0] abs_diff(input logic [COORD_WIDTH-1:0] a,
                                                        input logic [COORD_WIDTH-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    always_comb begin
        idle_like  = (state_q == StIdle) || (state_q == StDone);
        in_ready   = idle_like && (count_q < IDX_WIDTH'(MAX_POINTS)) && !start && !clear;
        accept     = in_valid && in_ready;
        do_clear   = idle_like && clear;
        do_start   = idle_like && start && !clear;
        few_points = count_q < IDX_WIDTH'(2);
        issue      = (state_q == StScan);
        j_step     = (32'(j_q) + NUM_ENGINES) < 32'(count_q);
        i_step     = (32'(i_q) + 32'd2) < 32'(count_q);

        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (do_clear) begin
                    state_d = StIdle;
                end else if (do_start) begin
                    state_d = few_points ? StDone : StScan;
                end else if (accept) begin
                    state_d = StIdle;
                end
            end
            StScan:  if (!j_step && !i_step) state_d = StDrain;
            StDrain: if (vld_q == '0) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Lanes past the loaded count read address 0 and are zeroed before the tree.
    always_comb begin
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            lane_ok[k]   = (32'(j_q) + k) < 32'(count_q);
            lane_addr[k] = lane_ok[k] ? ADDR_W'(j_q + IDX_WIDTH'(k)) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            result_q   <= '0;
            best_i_q   <= '0;
            best_j_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d == StScan) || (state_d == StDrain);
            finished_q <= (state_d == StDone);
            vld_q      <= {vld_q[VLD_W-2:0], issue};

            if (do_clear) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end

            if (do_start) begin
                i_q      <= '0;
                j_q      <= IDX_WIDTH'(1);
                result_q <= '0;
                best_i_q <= '0;
                best_j_q <= '0;
            end else begin
                if (issue) begin
                    if (j_step) begin
                        j_q <= j_q + IDX_WIDTH'(NUM_ENGINES);
                    end else if (i_step) begin
                        i_q <= i_q + 1'b1;
                        j_q <= i_q + IDX_WIDTH'(2);
                    end
                end
                // Strictly greater keeps the earliest-issued (smallest i,j) maximum.
                if (vld_q[VLD_W-1] && (node_area[0] > result_q)) begin
                    result_q <= node_area[0];
                    best_i_q <= node_i[0];
                    best_j_q <= node_j[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_x[ADDR_W'(count_q)] <= in_x;
            mem_y[ADDR_W'(count_q)] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        // S1: memory read
        xi1 <= mem_x[ADDR_W'(i_q)];
        yi1 <= mem_y[ADDR_W'(i_q)];
        lv1 <= lane_ok;
        i1  <= i_q;
        j1  <= j_q;
        {lv2, i2, j2} <= {lv1, i1, j1};
        {lv3, i3, j3} <= {lv2, i2, j2};
        {i4, j4}      <= {i3, j3};
        {i5, j5}      <= {i4, j4};
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            xj1[k] <= mem_x[lane_addr[k]];
            yj1[k] <= mem_y[lane_addr[k]];
            // S2: absolute differences
            dx2[k] <= abs_diff(xi1, xj1[k]);
            dy2[k] <= abs_diff(yi1, yj1[k]);
            // S3: inclusive extent, one bit wider
            wx3[k] <= WIDE_W'(dx2[k]) + WIDE_W'(1);
            wy3[k] <= WIDE_W'(dy2[k]) + WIDE_W'(1);
            // S4..S6: product followed by two registers for retiming
            p4[k]  <= lv3[k] ? AREA_WIDTH'(wx3[k]) * AREA_WIDTH'(wy3[k]) : '0;
            p5[k]  <= p4[k];
            node_area[NUM_ENGINES-1+k] <= p5[k];
            node_i[NUM_ENGINES-1+k]    <= i5;
            node_j[NUM_ENGINES-1+k]    <= j5 + IDX_WIDTH'(k);
        end
        // Max tree: left child holds the lower j, so it wins ties.
        for (int unsigned n = 0; n + 1 < NUM_ENGINES; n++) begin
            if (node_area[2*n+1] >= node_area[2*n+2]) begin
                node_area[n] <= node_area[2*n+1];
                node_i[n]    <= node_i[2*n+1];
                node_j[n]    <= node_j[2*n+1];
            end else begin
                node_area[n] <= node_area[2*n+2];
                node_i[n]    <= node_i[2*n+2];
                node_j[n]    <= node_j[2*n+2];
            end
        end
    end

    assign busy     = busy_q;
    assign finished = finished_q;
    assign result   = result_q;
    assign best_i   = best_i_q;
    assign best_j   = best_j_q;

endmodule

// File: tb/tb_movie_theater_max_rect.sv
// Bench for movie_theater_max_rect: three instances (1, 4 and 8 lanes) share one stimulus
// stream and are each checked against a brute-force pair search over the loaded points.
module tb_movie_theater_max_rect;

    localparam int unsigned MP = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 5;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, clear, start;
    logic [CW-1:0] in_x, in_y;
    logic          rdy [3];
    logic          bsy [3];
    logic          fin [3];
    logic [AW-1:0] res [3];
    logic [IW-1:0] bi  [3];
    logic [IW-1:0] bj  [3];

    int total = 0;
    int bad   = 0;
    int unsigned px[$];
    int unsigned py[$];

    always #5 clk = ~clk;

    movie_theater_max_rect #(.MAX_POINTS(MP), .COORD_WIDTH(CW), .NUM_ENGINES(1)) u_dut_ne1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_x(in_x), .in_y(in_y),
        .clear(clear), .start(start), .busy(bsy[0]), .finished(fin[0]), .result(res[0]),
        .best_i(bi[0]), .best_j(bj[0]));

    movie_theater_max_rect #(.MAX_POINTS(MP), .COORD_WIDTH(CW), .NUM_ENGINES(4)) u_dut_ne4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_x(in_x), .in_y(in_y),
        .clear(clear), .start(start), .busy(bsy[1]), .finished(fin[1]), .result(res[1]),
        .best_i(bi[1]), .best_j(bj[1]));

    movie_theater_max_rect #(.MAX_POINTS(MP), .COORD_WIDTH(CW), .NUM_ENGINES(8)) u_dut_ne8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_x(in_x), .in_y(in_y),
        .clear(clear), .start(start), .busy(bsy[2]), .finished(fin[2]), .result(res[2]),
        .best_i(bi[2]), .best_j(bj[2]));

    function automatic int unsigned ne_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    function automatic int unsigned log_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s ne=%0d observed=%0d expected=%0d", tag, ne_of(d), obs, exp);
        end
    endtask

    // Brute force over all i<j; strict > keeps the first maximal pair in (i,j) order.
    task automatic model(output logic [63:0] area, output int unsigned mi, output int unsigned mj);
        area = 0;
        mi   = 0;
        mj   = 0;
        for (int i = 0; i < px.size(); i++) begin
            for (int j = i + 1; j < px.size(); j++) begin
                logic [63:0] dx, dy, a;
                dx = (px[i] > px[j]) ? px[i] - px[j] : px[j] - px[i];
                dy = (py[i] > py[j]) ? py[i] - py[j] : py[j] - py[i];
                a  = (dx + 1) * (dy + 1);
                if (a > area) begin
                    area = a;
                    mi   = i;
                    mj   = j;
                end
            end
        end
    endtask

    function automatic int unsigned scan_len(input int unsigned n, input int unsigned ne);
        int unsigned s = 0;
        for (int unsigned i = 0; i + 1 < n; i++) s += (n - 1 - i + ne - 1) / ne;
        return s;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic load(input int unsigned x, input int unsigned y);
        in_valid = 1'b1;
        in_x     = CW'(x);
        in_y     = CW'(y);
        #1;
        for (int d = 0; d < 3; d++) chk("load_ready", d, 64'(rdy[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        px.push_back(x);
        py.push_back(y);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("clear_blocks_ready", d, 64'(rdy[d]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("ready_after_clear", d, 64'(rdy[d]), 64'd1);
        px.delete();
        py.delete();
    endtask

    task automatic run_check(input string tag);
        logic [63:0] ea;
        int unsigned ei, ej, n, sl, lat;
        int          bc [3];
        bit          all_done;
        model(ea, ei, ej);
        n = px.size();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (n < 2) begin
            for (int d = 0; d < 3; d++) begin
                chk({tag, "_fin_1cyc"}, d, 64'(fin[d]), 64'd1);
                chk({tag, "_busy_low"}, d, 64'(bsy[d]), 64'd0);
            end
        end
        for (int d = 0; d < 3; d++) bc[d] = 0;
        for (int c = 0; c < 3000; c++) begin
            all_done = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (fin[d] !== 1'b1) begin
                    all_done = 1'b0;
                    if (bsy[d] === 1'b1) bc[d]++;
                end
            end
            if (all_done) break;
            @(posedge clk);
            @(negedge clk);
        end
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_finished"}, d, 64'(fin[d]), 64'd1);
            chk({tag, "_result"}, d, 64'(res[d]), ea);
            chk({tag, "_best_i"}, d, 64'(bi[d]), 64'(ei));
            chk({tag, "_best_j"}, d, 64'(bj[d]), 64'(ej));
            if (n >= 2) begin
                // busy spans SCAN plus a drain of between L-1 and L+1 cycles.
                sl  = scan_len(n, ne_of(d));
                lat = 7 + log_of(d);
                total++;
                assert (bc[d] >= int'(sl + lat - 1) && bc[d] <= int'(sl + lat + 1)) else begin
                    bad++;
                    $error("FAIL %s_busy_len ne=%0d observed=%0d expected=%0d..%0d", tag,
                           ne_of(d), bc[d], sl + lat - 1, sl + lat + 1);
                end
            end
        end
    endtask

    initial begin
        int unsigned x, y;
        int          acc [3];
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        in_x     = '0;
        in_y     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy", d, 64'(bsy[d]), 64'd0);
            chk("reset_finished", d, 64'(fin[d]), 64'd0);
            chk("reset_result", d, 64'(res[d]), 64'd0);
            chk("reset_best_i", d, 64'(bi[d]), 64'd0);
            chk("reset_best_j", d, 64'(bj[d]), 64'd0);
            chk("reset_ready", d, 64'(rdy[d]), 64'd1);
        end
        rst = 1'b0;

        // Worked example; pair (2,6) also reaches 50 and must lose to (1,5).
        load(7, 1); load(11, 1); load(11, 7); load(9, 7);
        load(9, 5); load(2, 5);  load(2, 3);  load(7, 3);
        run_check("example");
        for (int d = 0; d < 3; d++) begin
            chk("example_area50", d, 64'(res[d]), 64'd50);
            chk("example_i1", d, 64'(bi[d]), 64'd1);
            chk("example_j5", d, 64'(bj[d]), 64'd5);
        end

        do_clear();
        run_check("count0");
        load(3, 4);
        for (int d = 0; d < 3; d++) chk("load_in_done_clears_fin", d, 64'(fin[d]), 64'd0);
        run_check("count1");

        do_clear();
        load(0, 0);
        load(255, 255);
        run_check("corner");
        for (int d = 0; d < 3; d++) chk("corner_65536", d, 64'(res[d]), 64'd65536);

        do_clear();
        repeat (10) load($urandom_range(0, 255), $urandom_range(0, 255));
        run_check("rand10");
        run_check("rescan");

        do_clear();
        repeat (16) load($urandom_range(0, 7), $urandom_range(0, 7));
        run_check("rand16_ties");

        // Hold in_valid for MP+3 beats; only MP points may be accepted.
        do_clear();
        for (int d = 0; d < 3; d++) acc[d] = 0;
        in_valid = 1'b1;
        for (int b = 0; b < int'(MP) + 3; b++) begin
            x    = $urandom_range(0, 255);
            y    = $urandom_range(0, 255);
            in_x = CW'(x);
            in_y = CW'(y);
            #1;
            for (int d = 0; d < 3; d++) if (rdy[d] === 1'b1) acc[d]++;
            if (rdy[0] === 1'b1) begin
                px.push_back(x);
                py.push_back(y);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("fill_accepted", d, 64'(acc[d]), 64'(MP));
            chk("fill_ready_low", d, 64'(rdy[d]), 64'd0);
        end
        run_check("full");
        do_clear();
        run_check("after_clear_empty");

        // Reset during SCAN, then a fresh run.
        @(negedge clk);
        repeat (10) load($urandom_range(0, 255), $urandom_range(0, 255));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("mid_scan_busy", d, 64'(bsy[d]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("abort_busy", d, 64'(bsy[d]), 64'd0);
            chk("abort_finished", d, 64'(fin[d]), 64'd0);
            chk("abort_result", d, 64'(res[d]), 64'd0);
            chk("abort_best_j", d, 64'(bj[d]), 64'd0);
        end
        rst = 1'b0;
        px.delete();
        py.delete();
        repeat (7) load($urandom_range(0, 255), $urandom_range(0, 255));
        run_check("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/movie_theater_max_rect.md
# movie_theater_max_rect

Parametrised all-pairs maximum-rectangle engine for the day-9 movie-theater datapath. Points are streamed in over a valid/ready port rather than preloaded from memory files. Once `start` is pulsed, the block evaluates every unordered pair (i<j) with NUM_ENGINES parallel lanes. It reports the largest inclusive rectangle area `(|xi-xj|+1)*(|yi-yj|+1)` and the index pair that produced it.

## Interface
- MAX_POINTS, 512, point-memory depth; count range 0..MAX_POINTS
- COORD_WIDTH, 32, unsigned coordinate width
- NUM_ENGINES, 8, parallel pair lanes; power of two, >=1
- IDX_WIDTH, $clog2(MAX_POINTS+1), index and count width
- AREA_WIDTH, 2*COORD_WIDTH+1, derived; result never overflows
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  point offered
- in_ready  out  1  point accepted when in_valid && in_ready
- in_x, in_y  in  COORD_WIDTH  point coordinates
- clear  in  1  empties point memory (count<=0), honoured in IDLE/DONE only
- start  in  1  begin scan over the points currently loaded
- busy  out  1  high in SCAN and DRAIN
- finished  out  1  high in DONE
- result  out  AREA_WIDTH  best area
- best_i, best_j  out  IDX_WIDTH  indices of the winning pair, best_i<best_j

## Operation
- States: IDLE, SCAN, DRAIN, DONE. Reset puts the block in IDLE with count=0, all valids=0, finished=0, busy=0, result=0, best_i=best_j=0. Memory contents are not cleared.
- `in_ready = (IDLE||DONE) && count<MAX_POINTS && !start && !clear`. An accepted point is written at index count, then count increments. Accepting a point in DONE moves the block to IDLE and clears `finished`.
- Priority in IDLE/DONE is `clear` > `start` > load. `start` clears `finished`, `result` and `best_*`.
- `start` with count<2: go to DONE on the next cycle with result=0 and best_i=best_j=0.
- `start` with count>=2: enter SCAN with i=0, j=1.
- SCAN, each cycle: issue lanes k=0..NUM_ENGINES-1 for pair (i, j+k). Lane valid iff j+k<count.
  - If j+NUM_ENGINES<count: j+=NUM_ENGINES.
  - Else if i<count-2: i+=1 and j=i+2.
  - Else: go to DRAIN.
- Pipeline:
  - S1: memory read.
  - S2: absolute differences.
  - S3: +1, widened to COORD_WIDTH+1.
  - S4–S6: multiply, retimable over 3 registers.
  - log2(NUM_ENGINES) stages: pairwise max tree.
  - One stage: global update.
- Invalid lanes enter the tree as area 0.
- Tie-break: the tree keeps the lower-j lane when areas are equal. The global register updates only when the incoming area is strictly greater. The reported pair is therefore the lexicographically smallest (i,j) among maximal pairs.
- DRAIN: no issue. When every pipeline valid is 0, go to DONE.
- DONE: result and best_* hold and finished=1 until `start`, `clear` or an accepted point. `start` in DONE rescans the same points.
- `start` and `clear` are ignored in SCAN and DRAIN. Reset in any state aborts immediately to reset values.

## Timing
- Pipeline depth L = 7 + log2(NUM_ENGINES) cycles from issue to global register.
- SCAN length is the sum over i=0..count-2 of ceil((count-1-i)/NUM_ENGINES) cycles.
- `finished` rises within L+2 cycles of the last SCAN cycle.
- count<2 case: `finished` rises 1 cycle after `start`.
- All outputs are registered except `in_ready`, which is combinational from state, count, start and clear.

## Test plan
- Load (7,1),(11,1),(11,7),(9,7),(9,5),(2,5),(2,3),(7,3), then start → result=50, best_i=1, best_j=5. Pair (2,6) also gives 50 and must lose the tie.
- count=1, start → finished exactly 1 cycle later, result=0, best_i=best_j=0. Same for count=0.
- COORD_WIDTH=8, points (0,0) and (255,255) → result=65536 (17 bits), best=(0,1).
- NUM_ENGINES ∈ {1,4,8}, count=10 and count=MAX_POINTS, random coordinates → result and best pair match a software model. SCAN cycle count matches the formula.
- Hold in_valid high for MAX_POINTS+3 beats → exactly MAX_POINTS points accepted and in_ready low afterwards. `clear` → in_ready high and count=0.
- Assert rst mid-SCAN → next edge shows busy=0, finished=0, result=0. Reload, start, and a correct result follows.
